// File: rtl/hex_disp_pkg.sv
// Shared constants and helpers for the hex scan counter / display block.
//   SCAN_DIV_DEFAULT : cycles each digit stays selected at 100 MHz
//   TICK_DIV_DEFAULT : cycles between count steps (1 Hz at 100 MHz)
//   clog2            : ceiling log2 for elaboration-time width sizing
//   nibble_clamp_bcd : limits a loaded nibble to a legal decimal digit
package hex_disp_pkg;

  localparam int unsigned SCAN_DIV_DEFAULT = 250000;
  localparam int unsigned TICK_DIV_DEFAULT = 100000000;

  // Ceiling log2; returns 0 for v <= 1 so callers apply their own minimum width.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  // Any nibble above 9 is stored as 9.
  function automatic logic [3:0] nibble_clamp_bcd(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// Single decimal digit step cell with carry/borrow ripple.
//   i_digit   : current digit value (0..9)
//   i_dir     : 0 = increment, 1 = decrement
//   i_cin     : carry (up) or borrow (down) from the lower digit; 0 holds
//   o_digit_c : next digit value (combinational)
//   o_cout_c  : carry/borrow to the next digit (combinational)
module bcd_digit (
  input  logic [3:0] i_digit,
  input  logic       i_dir,
  input  logic       i_cin,
  output logic [3:0] o_digit_c,
  output logic       o_cout_c
);

  always_comb begin
    o_digit_c = i_digit;
    o_cout_c  = 1'b0;
    if (i_cin) begin
      if (!i_dir) begin
        // Anything at or above 9 rolls to 0 so a corrupt digit self-heals.
        if (i_digit >= 4'd9) begin
          o_digit_c = 4'd0;
          o_cout_c  = 1'b1;
        end else begin
          o_digit_c = i_digit + 4'd1;
        end
      end else begin
        if (i_digit == 4'd0) begin
          o_digit_c = 4'd9;
          o_cout_c  = 1'b1;
        end else begin
          o_digit_c = i_digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/hex_scan_counter.sv
// DIGITS-nibble up/down counter (binary or BCD) with enable, parallel load and
// wrap pulse, time-multiplexed onto the hexplay digit-select/data pins.
//   CLK100MHZ    : system clock, rising edge
//   rst          : synchronous active-high reset
//   en           : count enable (pauses tick divider and counter when 0)
//   dir          : 0 = up, 1 = down, sampled on the step cycle
//   load         : parallel load strobe (wins over a coincident step)
//   load_val     : value loaded on load (nibbles clamped to 9 in BCD mode)
//   count        : registered counter value
//   tc           : one-cycle pulse accompanying a wrapped count value
//   hexplay_an   : registered selected digit index
//   hexplay_data : combinational nibble of count for the selected digit
module hex_scan_counter
  import hex_disp_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned AN_W     = 3,
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT,
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned BCD      = 0
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  dir,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic [AN_W-1:0]       hexplay_an,
  output logic [3:0]            hexplay_data
);

  localparam int unsigned CW     = 4 * DIGITS;
  localparam int unsigned SCAN_W = (clog2(SCAN_DIV) > 0) ? clog2(SCAN_DIV) : 1;
  localparam int unsigned TICK_W = (clog2(TICK_DIV) > 0) ? clog2(TICK_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [AN_W-1:0]   AN_LAST   = AN_W'(DIGITS - 1);

  logic [SCAN_W-1:0] r_scan;
  logic [AN_W-1:0]   r_an;
  logic [TICK_W-1:0] r_tick;
  logic [CW-1:0]     r_count;
  logic              r_tc;

  logic              w_step;
  logic [CW-1:0]     w_next;
  logic              w_wrap;
  logic [CW-1:0]     w_load;
  logic [3:0]        w_data;

  // Digit scan: each index held SCAN_DIV cycles, wrapping at DIGITS-1.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      r_scan <= '0;
      r_an   <= '0;
    end else if (r_scan == SCAN_LAST) begin
      r_scan <= '0;
      r_an   <= (r_an == AN_LAST) ? '0 : r_an + AN_W'(1);
    end else begin
      r_scan <= r_scan + SCAN_W'(1);
    end
  end

  assign w_step = en && (r_tick == TICK_LAST);

  // Tick divider: frozen while disabled, cleared by load.
  always_ff @(posedge CLK100MHZ) begin
    if (rst || load) begin
      r_tick <= '0;
    end else if (en) begin
      r_tick <= w_step ? '0 : r_tick + TICK_W'(1);
    end
  end

  // Next-value datapath: digit-serial ripple in BCD, plain add/sub in binary.
  if (BCD != 0) begin : g_bcd
    logic [DIGITS:0] w_carry;
    assign w_carry[0] = 1'b1;
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dig
      bcd_digit u_digit (
        .i_digit   (r_count[4*g +: 4]),
        .i_dir     (dir),
        .i_cin     (w_carry[g]),
        .o_digit_c (w_next[4*g +: 4]),
        .o_cout_c  (w_carry[g+1])
      );
      assign w_load[4*g +: 4] = nibble_clamp_bcd(load_val[4*g +: 4]);
    end
    assign w_wrap = w_carry[DIGITS];
  end else begin : g_bin
    assign w_next = dir ? (r_count - CW'(1)) : (r_count + CW'(1));
    assign w_wrap = dir ? (r_count == '0) : (&r_count);
    assign w_load = load_val;
  end

  // Counter and wrap flag; tc only follows a step that wrapped.
  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= w_load;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      r_count <= w_next;
      r_tc    <= w_wrap;
    end else begin
      r_tc    <= 1'b0;
    end
  end

  // Selected nibble mux; unused index codes read as 0.
  always_comb begin
    w_data = 4'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_an == AN_W'(i)) w_data = r_count[4*i +: 4];
    end
  end

  assign count        = r_count;
  assign tc           = r_tc;
  assign hexplay_an   = r_an;
  assign hexplay_data = w_data;

endmodule

// File: tb/tb_hex_scan_counter.sv
// Bench for hex_scan_counter: binary, BCD and 3-digit instances share stimulus.
module tb_hex_scan_counter;

  logic        clk = 1'b0;
  logic        rst, en, dir, load;
  logic [15:0] load_val;

  logic [15:0] cnt_b, cnt_d;
  logic [11:0] cnt_3;
  logic        tc_b, tc_d, tc_3;
  logic [1:0]  an_b, an_d, an_3;
  logic [3:0]  dat_b, dat_d, dat_3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hex_scan_counter #(.DIGITS(4), .AN_W(2), .SCAN_DIV(4), .TICK_DIV(10), .BCD(0)) u_bin (
    .CLK100MHZ(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .count(cnt_b), .tc(tc_b), .hexplay_an(an_b), .hexplay_data(dat_b));

  hex_scan_counter #(.DIGITS(4), .AN_W(2), .SCAN_DIV(4), .TICK_DIV(10), .BCD(1)) u_bcd (
    .CLK100MHZ(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val),
    .count(cnt_d), .tc(tc_d), .hexplay_an(an_d), .hexplay_data(dat_d));

  hex_scan_counter #(.DIGITS(3), .AN_W(2), .SCAN_DIV(3), .TICK_DIV(5), .BCD(0)) u_d3 (
    .CLK100MHZ(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_val(load_val[11:0]),
    .count(cnt_3), .tc(tc_3), .hexplay_an(an_3), .hexplay_data(dat_3));

  // Reference model: value kept as a nibble pattern, stepped as an integer in base 10 or 16.
  typedef struct {
    logic [31:0] val;
    int unsigned tick;
    int unsigned scan;
    bit          tc;
  } mdl_t;

  mdl_t m_b, m_d, m_3;

  function automatic mdl_t mdl_next(mdl_t m, int digits, int sdiv, int tdiv, bit bcd,
                                    bit r, bit e, bit d, bit ld, logic [31:0] lv);
    mdl_t   n;
    longint base, md, v, mult;
    logic [3:0] nib;
    n = m;
    if (r) begin
      n.val = 0; n.tick = 0; n.scan = 0; n.tc = 0;
      return n;
    end
    n.scan = (m.scan + 1) % (sdiv * digits);
    n.tc   = 0;
    base   = bcd ? 10 : 16;
    if (ld) begin
      n.val = 0;
      for (int i = 0; i < digits; i++) begin
        nib = lv[4*i +: 4];
        if (bcd && nib > 4'd9) nib = 4'd9;
        n.val[4*i +: 4] = nib;
      end
      n.tick = 0;
    end else if (e) begin
      if (m.tick == 32'(tdiv - 1)) begin
        n.tick = 0;
        md = 1; v = 0; mult = 1;
        for (int i = 0; i < digits; i++) begin
          v    += longint'(m.val[4*i +: 4]) * mult;
          mult *= base;
          md   *= base;
        end
        n.tc = d ? (v == 0) : (v == md - 1);
        v    = d ? (v + md - 1) % md : (v + 1) % md;
        n.val = 0;
        mult = 1;
        for (int i = 0; i < digits; i++) begin
          n.val[4*i +: 4] = 4'((v / mult) % base);
          mult *= base;
        end
      end else begin
        n.tick = m.tick + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_inst(input string nm, input mdl_t m, input int sdiv,
                          input logic [31:0] c, input logic t, input logic [1:0] a, input logic [3:0] dt);
    int unsigned xa;
    xa = m.scan / 32'(sdiv);
    chk({nm, ".count"}, c, m.val);
    chk({nm, ".tc"}, 32'(t), 32'(m.tc));
    chk({nm, ".an"}, 32'(a), xa);
    chk({nm, ".data"}, 32'(dt), 32'(m.val[4*xa +: 4]));
  endtask

  // One clock: drive inputs, advance models on the edge, compare just after it.
  task automatic cyc(input bit r, input bit e, input bit d, input bit ld, input logic [15:0] lv);
    rst = r; en = e; dir = d; load = ld; load_val = lv;
    @(posedge clk);
    m_b = mdl_next(m_b, 4, 4, 10, 1'b0, r, e, d, ld, {16'h0, lv});
    m_d = mdl_next(m_d, 4, 4, 10, 1'b1, r, e, d, ld, {16'h0, lv});
    m_3 = mdl_next(m_3, 3, 3, 5, 1'b0, r, e, d, ld, {20'h0, lv[11:0]});
    #1;
    chk_inst("bin", m_b, 4, {16'h0, cnt_b}, tc_b, an_b, dat_b);
    chk_inst("bcd", m_d, 4, {16'h0, cnt_d}, tc_d, an_d, dat_d);
    chk_inst("d3", m_3, 3, {20'h0, cnt_3}, tc_3, an_3, dat_3);
  endtask

  typedef struct {
    bit          r, e, d, ld;
    logic [15:0] lv;
    int          n;
    logic [15:0] xb, xd;
    bit          tb, td;
  } vec_t;

  vec_t        tbl[$];
  logic [3:0]  dig[4];
  logic [15:0] lv;

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    m_b = '{val: 0, tick: 0, scan: 0, tc: 0};
    m_d = m_b;
    m_3 = m_b;

    // Scan order and digit data with a held value and counting paused.
    dig = '{4'h4, 4'h3, 4'h2, 4'h1};
    cyc(1, 0, 0, 0, 16'h0);
    for (int k = 1; k < 20; k++) begin
      cyc(0, 0, 0, k == 1, 16'h1234);
      chk("scan.an", 32'(an_b), 32'((k / 4) % 4));
      chk("scan.data_bin", 32'(dat_b), 32'(dig[(k / 4) % 4]));
      chk("scan.data_bcd", 32'(dat_d), 32'(dig[(k / 4) % 4]));
    end

    // {rst,en,dir,load,load_val, cycles, bin count, bcd count, bin tc, bcd tc}
    tbl.push_back('{1,0,0,0,16'h0000, 1, 16'h0000,16'h0000,0,0});
    tbl.push_back('{0,0,0,1,16'hFFFE, 1, 16'hFFFE,16'h9999,0,0});
    tbl.push_back('{0,1,0,0,16'h0000,10, 16'hFFFF,16'h0000,0,1});
    tbl.push_back('{0,1,0,0,16'h0000, 1, 16'hFFFF,16'h0000,0,0});
    tbl.push_back('{0,1,0,0,16'h0000, 9, 16'h0000,16'h0001,1,0});
    tbl.push_back('{0,1,1,0,16'h0000, 1, 16'h0000,16'h0001,0,0});
    tbl.push_back('{0,1,1,0,16'h0000, 9, 16'hFFFF,16'h0000,1,0});
    tbl.push_back('{0,1,1,0,16'h0000,10, 16'hFFFE,16'h9999,0,1});
    tbl.push_back('{0,0,0,1,16'h0099, 1, 16'h0099,16'h0099,0,0});
    tbl.push_back('{0,1,0,0,16'h0000,10, 16'h009A,16'h0100,0,0});
    tbl.push_back('{0,1,0,0,16'h0000, 9, 16'h009A,16'h0100,0,0});
    tbl.push_back('{0,1,0,1,16'h00AB, 1, 16'h00AB,16'h0099,0,0});
    tbl.push_back('{0,1,0,0,16'h0000, 9, 16'h00AB,16'h0099,0,0});
    tbl.push_back('{0,1,0,0,16'h0000, 1, 16'h00AC,16'h0100,0,0});
    tbl.push_back('{0,1,0,0,16'h0000, 6, 16'h00AC,16'h0100,0,0});
    tbl.push_back('{0,0,0,0,16'h0000, 5, 16'h00AC,16'h0100,0,0});
    tbl.push_back('{0,1,0,0,16'h0000, 3, 16'h00AC,16'h0100,0,0});
    tbl.push_back('{0,1,0,0,16'h0000, 1, 16'h00AD,16'h0101,0,0});
    tbl.push_back('{0,1,0,0,16'h0000, 7, 16'h00AD,16'h0101,0,0});
    tbl.push_back('{1,1,0,0,16'h0000, 1, 16'h0000,16'h0000,0,0});
    tbl.push_back('{0,1,0,0,16'h0000, 9, 16'h0000,16'h0000,0,0});
    tbl.push_back('{0,1,0,0,16'h0000, 1, 16'h0001,16'h0001,0,0});

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++)
        cyc(tbl[i].r, tbl[i].e, tbl[i].d, tbl[i].ld, tbl[i].lv);
      chk($sformatf("vec%0d.bin_count", i), 32'(cnt_b), 32'(tbl[i].xb));
      chk($sformatf("vec%0d.bcd_count", i), 32'(cnt_d), 32'(tbl[i].xd));
      chk($sformatf("vec%0d.bin_tc", i), 32'(tc_b), 32'(tbl[i].tb));
      chk($sformatf("vec%0d.bcd_tc", i), 32'(tc_d), 32'(tbl[i].td));
    end

    // Random traffic, biased toward loads of wrap-boundary values.
    for (int k = 0; k < 3000; k++) begin
      case ($urandom_range(0, 3))
        0:       lv = 16'h0000;
        1:       lv = 16'hFFFF;
        2:       lv = 16'h9999;
        default: lv = 16'($urandom);
      endcase
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0, lv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_scan_counter.md
Name: hex_scan_counter

Overview:
Parametrised successor to the board's fixed 8-digit hex counter/display block. It holds a DIGITS-nibble up/down counter with enable, parallel load, optional BCD (decimal) mode and a wrap pulse. It time-multiplexes the value onto the FPGAOL hexplay digit-select/data pins. It sits at the top level, driven by switches/buttons, or used as a status display by other blocks.

Parameters:
DIGITS, 8, number of displayed digits / counter nibbles (1..8)
AN_W, 3, width of hexplay_an; must be at least clog2(DIGITS) and at least 1
SCAN_DIV, 250000, clock cycles each digit stays selected (>=1)
TICK_DIV, 100000000, clock cycles between count steps while enabled (>=1)
BCD, 0, 0 = binary modulo 2^(4*DIGITS); 1 = each nibble counts 0..9

Ports:
CLK100MHZ  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  count enable; 0 pauses the tick divider and the counter
dir  in  1  0 = increment, 1 = decrement; sampled on the step cycle
load  in  1  parallel load strobe, level-sensitive per cycle
load_val  in  4*DIGITS  value loaded when load=1
count  out  4*DIGITS  current counter value (registered)
tc  out  1  one-cycle pulse after a step that wrapped
hexplay_an  out  AN_W  selected digit index
hexplay_data  out  4  nibble of count for the selected digit

Behaviour:
- Reset (rst=1 at an edge): count=0, tc=0, hexplay_an=0, scan and tick dividers=0. Takes effect at that edge, including mid-scan or mid-tick.
- Scan divider counts 0..SCAN_DIV-1. On the edge where it equals SCAN_DIV-1, it returns to 0 and hexplay_an advances. hexplay_an wraps from DIGITS-1 to 0. Each digit is selected for exactly SCAN_DIV cycles, including non-power-of-2 DIGITS.
- hexplay_data is combinational: count[4*hexplay_an+3 : 4*hexplay_an]. Zero latency from hexplay_an and count.
- Tick divider advances only while en=1 and counts 0..TICK_DIV-1. The step fires in the cycle it equals TICK_DIV-1 with en=1, and the divider then returns to 0. While en=0 the divider holds its value; it does not reset.
- Step, binary mode: count +1 or -1 modulo 2^(4*DIGITS). Wrap occurs at all-F -> 0 on increment and 0 -> all-F on decrement.
- Step, BCD mode: digit-serial decimal carry/borrow. 9 -> 0 with carry up; 0 -> 9 with borrow. Wrap occurs at 99..9 -> 0 and 0 -> 99..9.
- tc: registered; high for exactly the one cycle following a wrapping step. It appears together with the wrapped count value and is otherwise 0.
- Load: count <= load_val, tick divider <= 0, tc <= 0. In BCD mode, any load_val nibble >9 is stored as 9.
- Priority: rst > load > step. A load coinciding with a step discards the step, and tc stays 0.
- The scan path is independent of en, load and dir; only rst affects it.
- Outputs never glitch from dir changes between steps.

Decomposition:
- Package hex_disp_pkg holds:
  - the default divider constants (SCAN_DIV_DEFAULT, TICK_DIV_DEFAULT);
  - a clog2 function;
  - a nibble_clamp_bcd function.
- One sub-module, bcd_digit: a single 4-bit digit with up/down, carry/borrow-in and carry/borrow-out. It is generated DIGITS times when BCD=1. Binary mode uses a single 4*DIGITS-bit adder/subtractor.

Test Plan (DIGITS=4, AN_W=2, SCAN_DIV=4, TICK_DIV=10 unless stated):
1. Scan: rst, then load 0x1234, en=0 -> hexplay_an steps 0,1,2,3,0, each held 4 cycles. hexplay_data reads 4,3,2,1 correspondingly.
2. Binary wrap: load 0xFFFE, en=1, dir=0 -> count=0xFFFF after 10 cycles and 0x0000 after 20. tc=1 for exactly one cycle with count=0x0000. dir=1 then gives 0xFFFF after 10 more cycles, with a second tc pulse.
3. BCD wrap: BCD=1, load 0x0001, dir=1 -> count 0x0000, then 0x9999 with a tc pulse. Load 0x0099 with dir=0 -> 0x0100, and no tc.
4. Pause: en=1 until the tick divider reads 6, then en=0 for 5 cycles, then en=1 -> the step occurs 4 cycles after re-enable and count changes by exactly 1.
5. Load/step collision plus clamp: BCD=1, assert load with load_val=0x00AB on the step cycle -> count=0x0099, no step applied, tc=0. The next step occurs 10 cycles later.
6. Mid-operation reset: with hexplay_an=2, count=0x1234 and the tick divider at 7, pulse rst for one cycle. At the next edge: count=0, hexplay_an=0, tc=0, and the first step occurs 10 enabled cycles after rst deasserts.
